// File: rtl/cdc_pkg.sv
// Shared encodings for the CDC transmit arbiter: FSM states and requester indices.
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WAIT_LO = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop level synchronizer; every bit passes through NUM_STAGES flops.
module bit_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [BUS_WIDTH-1:0] i_d,
  output logic [BUS_WIDTH-1:0] o_q
);

  logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[NUM_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[NUM_STAGES-1];

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Round-robin source-side controller sharing one CDC data channel between two
// requesters; 4-phase handshake on a level enable with optional ack timeout.
module cdc_tx_arbiter
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int ACK_STAGES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0,
  input  logic [BUS_WIDTH-1:0] data0,
  input  logic                 req1,
  input  logic [BUS_WIDTH-1:0] data1,
  input  logic                 tx_ack_async,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [BUS_WIDTH-1:0] tx_bus,
  output logic                 tx_valid,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int             CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  state_t                r_state, w_state;
  logic [BUS_WIDTH-1:0]  r_bus, w_bus;
  logic                  r_valid, w_valid;
  logic [1:0]            r_gnt, w_gnt;
  logic [1:0]            r_done, w_done;
  logic                  r_to, w_to;
  logic                  r_last, w_last;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  w_ack;
  logic                  w_sel;

  bit_sync #(.NUM_STAGES(ACK_STAGES), .BUS_WIDTH(1)) u_ack_sync (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_d     (tx_ack_async),
    .o_q     (w_ack)
  );

  // Lone requester wins outright; on contention the one not served last wins.
  assign w_sel = (req0 & req1) ? ~r_last : (req1 ? REQ1 : REQ0);

  always_comb begin
    w_state = r_state;
    w_bus   = r_bus;
    w_valid = r_valid;
    w_gnt   = '0;
    w_done  = '0;
    w_to    = 1'b0;
    w_last  = r_last;
    w_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!w_ack && (req0 | req1)) begin
          w_bus        = (w_sel == REQ1) ? data1 : data0;
          w_valid      = 1'b1;
          w_gnt[w_sel] = 1'b1;
          w_last       = w_sel;
          w_cnt        = '0;
          w_state      = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        // Ack is checked first so it wins a same-cycle collision with timeout.
        if (w_ack) begin
          w_valid         = 1'b0;
          w_done[r_last]  = 1'b1;
          w_state         = ST_WAIT_LO;
        end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
          w_valid = 1'b0;
          w_to    = 1'b1;
          w_state = ST_WAIT_LO;
        end else if (r_cnt != {CW{1'b1}}) begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!w_ack) w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_bus   <= '0;
      r_valid <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_to    <= 1'b0;
      r_last  <= REQ1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_bus   <= w_bus;
      r_valid <= w_valid;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_to    <= w_to;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
    end
  end

  assign gnt0        = r_gnt[REQ0];
  assign gnt1        = r_gnt[REQ1];
  assign done0       = r_done[REQ0];
  assign done1       = r_done[REQ1];
  assign tx_bus      = r_bus;
  assign tx_valid    = r_valid;
  assign timeout_err = r_to;
  assign busy        = (r_state != ST_IDLE);

endmodule
